text_writer: RTL and testbench

- Write-side engine for the 32x32 character text buffer scanned by the tile layer.
- Accepts a byte stream of characters over a valid/ready handshake and writes glyph codes into the buffer's write port.
- Maintains a cursor and handles CR, LF, backspace and line wrap.
- Implements scrolling as a circular row pointer, o_scroll_row, which the top level multiplies by 8 to drive the tile layer's i_offset_y.

---
 rtl/text_writer_if.sv | 38 +++
 rtl/text_writer.sv | 150 +++++++++++++++
 tb/tb_text_writer.sv | 338 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/text_writer_if.sv
// Character-stream and text-buffer write-port bundle for text_writer.
//   master : character source / buffer consumer (drives i_*, observes o_*)
//   slave  : the text_writer engine
// Signals:
//   i_char_valid / i_char / o_char_ready : byte stream handshake
//   i_clear                              : one-cycle request to blank the buffer
//   o_wr_en / o_wr_addr / o_wr_data      : registered text buffer write port
//   o_cursor_col / o_cursor_row          : current cursor position
//   o_scroll_row                         : buffer row shown at the top of the screen
//   o_busy                               : a line or full-buffer clear is in progress
interface text_writer_if #(
   parameter int unsigned COL_BITS = 5,
   parameter int unsigned ROW_BITS = 5
);
   logic                         i_char_valid;
   logic [7:0]                   i_char;
   logic                         o_char_ready;
   logic                         i_clear;
   logic                         o_wr_en;
   logic [ROW_BITS+COL_BITS-1:0] o_wr_addr;
   logic [7:0]                   o_wr_data;
   logic [COL_BITS-1:0]          o_cursor_col;
   logic [ROW_BITS-1:0]          o_cursor_row;
   logic [ROW_BITS-1:0]          o_scroll_row;
   logic                         o_busy;

   modport master (
      output i_char_valid, i_char, i_clear,
      input  o_char_ready, o_wr_en, o_wr_addr, o_wr_data,
      input  o_cursor_col, o_cursor_row, o_scroll_row, o_busy
   );

   modport slave (
      input  i_char_valid, i_char, i_clear,
      output o_char_ready, o_wr_en, o_wr_addr, o_wr_data,
      output o_cursor_col, o_cursor_row, o_scroll_row, o_busy
   );
endinterface

// File: rtl/text_writer.sv
// Write-side engine for the character text buffer scanned by the tile layer.
// Consumes a byte stream, writes glyph codes at the cursor, handles CR, LF,
// backspace and line wrap, and scrolls by advancing a circular top-row pointer.
// Ports:
//   i_pix_clk : pixel clock, all logic on posedge
//   i_rst_n   : asynchronous active-low reset
//   bus       : text_writer_if slave (handshake, write port, cursor, scroll, busy)
module text_writer #(
   parameter int unsigned COL_BITS   = 5,
   parameter int unsigned ROW_BITS   = 5,
   parameter logic [7:0]  BLANK_CHAR = 8'h20
) (
   input  logic         i_pix_clk,
   input  logic         i_rst_n,
   text_writer_if.slave bus
);
   localparam int unsigned ADDR_BITS = ROW_BITS + COL_BITS;
   localparam logic [COL_BITS-1:0] LAST_COL = '1;
   localparam logic [COL_BITS:0] LINE_ONE = (COL_BITS+1)'(1);

   typedef enum logic [1:0] {
      StIdle,
      StClearLine,
      StClearAll
   } state_e;

   state_e                state_q;
   logic [COL_BITS-1:0]   col_q;
   logic [ROW_BITS-1:0]   row_q;
   logic [ROW_BITS-1:0]   scroll_q;
   // Extra MSB marks "all writes issued"; the following cycle returns to idle,
   // so ready only rises once the last clear write has been presented.
   logic [ADDR_BITS:0]    fill_cnt_q;
   logic [COL_BITS:0]     line_cnt_q;
   logic                  wr_en_q;
   logic [ADDR_BITS-1:0]  wr_addr_q;
   logic [7:0]            wr_data_q;

   logic                  char_ready;
   logic [ROW_BITS-1:0]   row_next;
   logic [COL_BITS-1:0]   col_prev;
   logic                  buffer_full;

   assign char_ready  = (state_q == StIdle) && !bus.i_clear;
   assign row_next    = row_q + 1'b1;
   assign col_prev    = col_q - 1'b1;
   // A newline landing on the top visible row means the screen is full.
   assign buffer_full = (row_next == scroll_q);

   always_ff @(posedge i_pix_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q    <= StClearAll;
         col_q      <= '0;
         row_q      <= '0;
         scroll_q   <= '0;
         fill_cnt_q <= '0;
         line_cnt_q <= '0;
         wr_en_q    <= 1'b0;
         wr_addr_q  <= '0;
         wr_data_q  <= '0;
      end else begin
         wr_en_q <= 1'b0;
         if (bus.i_clear) begin
            state_q    <= StClearAll;
            fill_cnt_q <= '0;
         end else begin
            case (state_q)
               StIdle: begin
                  if (bus.i_char_valid) begin
                     case (bus.i_char)
                        8'h0D: col_q <= '0;
                        8'h0A: begin
                           col_q <= '0;
                           row_q <= row_next;
                           if (buffer_full) begin
                              // No own write for LF, so the first clear write
                              // takes this slot.
                              scroll_q   <= scroll_q + 1'b1;
                              state_q    <= StClearLine;
                              wr_en_q    <= 1'b1;
                              wr_addr_q  <= {row_next, {COL_BITS{1'b0}}};
                              wr_data_q  <= BLANK_CHAR;
                              line_cnt_q <= LINE_ONE;
                           end
                        end
                        8'h08: begin
                           if (col_q != '0) begin
                              col_q     <= col_prev;
                              wr_en_q   <= 1'b1;
                              wr_addr_q <= {row_q, col_prev};
                              wr_data_q <= BLANK_CHAR;
                           end
                        end
                        default: begin
                           wr_en_q   <= 1'b1;
                           wr_addr_q <= {row_q, col_q};
                           wr_data_q <= bus.i_char;
                           if (col_q != LAST_COL) begin
                              col_q <= col_q + 1'b1;
                           end else begin
                              col_q <= '0;
                              row_q <= row_next;
                              if (buffer_full) begin
                                 scroll_q   <= scroll_q + 1'b1;
                                 state_q    <= StClearLine;
                                 line_cnt_q <= '0;
                              end
                           end
                        end
                     endcase
                  end
               end
               StClearLine: begin
                  if (!line_cnt_q[COL_BITS]) begin
                     wr_en_q    <= 1'b1;
                     wr_addr_q  <= {row_q, line_cnt_q[COL_BITS-1:0]};
                     wr_data_q  <= BLANK_CHAR;
                     line_cnt_q <= line_cnt_q + 1'b1;
                  end else begin
                     state_q <= StIdle;
                  end
               end
               StClearAll: begin
                  if (!fill_cnt_q[ADDR_BITS]) begin
                     wr_en_q    <= 1'b1;
                     wr_addr_q  <= fill_cnt_q[ADDR_BITS-1:0];
                     wr_data_q  <= BLANK_CHAR;
                     fill_cnt_q <= fill_cnt_q + 1'b1;
                  end else begin
                     state_q  <= StIdle;
                     col_q    <= '0;
                     row_q    <= '0;
                     scroll_q <= '0;
                  end
               end
               default: state_q <= StIdle;
            endcase
         end
      end
   end

   assign bus.o_char_ready = char_ready;
   assign bus.o_wr_en      = wr_en_q;
   assign bus.o_wr_addr    = wr_addr_q;
   assign bus.o_wr_data    = wr_data_q;
   assign bus.o_cursor_col = col_q;
   assign bus.o_cursor_row = row_q;
   assign bus.o_scroll_row = scroll_q;
   assign bus.o_busy       = (state_q != StIdle);
endmodule

// File: tb/tb_text_writer.sv
// Directed bench for text_writer: power-up fill, printing, wrap, backspace,
// LF scrolling with line clear, clear requests and asynchronous reset.
module tb_text_writer;
   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   errors = 0;
   int   checks = 0;

   always #5 clk = ~clk;

   text_writer_if bus ();

   text_writer dut (
      .i_pix_clk (clk),
      .i_rst_n   (rst_n),
      .bus       (bus)
   );

   task automatic test_reset();
      rst_n = 1'b0;
      @(negedge clk);
      checks++;
      if (bus.o_wr_en !== 1'b0 || bus.o_wr_addr !== 10'd0 || bus.o_wr_data !== 8'h00 ||
          bus.o_char_ready !== 1'b0 || bus.o_busy !== 1'b1) begin
         errors++;
         $display("FAIL reset_outputs: en=%b addr=%0d data=%h rdy=%b busy=%b, want 0 0 00 0 1",
                  bus.o_wr_en, bus.o_wr_addr, bus.o_wr_data, bus.o_char_ready, bus.o_busy);
      end
      checks++;
      if (bus.o_cursor_col !== 5'd0 || bus.o_cursor_row !== 5'd0 || bus.o_scroll_row !== 5'd0) begin
         errors++;
         $display("FAIL reset_cursor: col=%0d row=%0d scroll=%0d, want 0 0 0",
                  bus.o_cursor_col, bus.o_cursor_row, bus.o_scroll_row);
      end
      rst_n = 1'b1;
      for (int i = 0; i < 1024; i++) begin
         @(negedge clk);
         checks++;
         if (bus.o_wr_en !== 1'b1 || bus.o_wr_addr !== 10'(i) || bus.o_wr_data !== 8'h20 ||
             bus.o_char_ready !== 1'b0) begin
            errors++;
            $display("FAIL fill[%0d]: en=%b addr=%0d data=%h rdy=%b, want en=1 addr=%0d data=20 rdy=0",
                     i, bus.o_wr_en, bus.o_wr_addr, bus.o_wr_data, bus.o_char_ready, i);
         end
      end
      @(negedge clk);
      checks++;
      if (bus.o_char_ready !== 1'b1 || bus.o_wr_en !== 1'b0 || bus.o_busy !== 1'b0 ||
          bus.o_cursor_col !== 5'd0 || bus.o_cursor_row !== 5'd0 || bus.o_scroll_row !== 5'd0) begin
         errors++;
         $display("FAIL fill_done: rdy=%b en=%b busy=%b col=%0d row=%0d scroll=%0d, want 1 0 0 0 0 0",
                  bus.o_char_ready, bus.o_wr_en, bus.o_busy, bus.o_cursor_col,
                  bus.o_cursor_row, bus.o_scroll_row);
      end
   endtask

   task automatic test_back_to_back();
      bus.i_char_valid = 1'b1;
      bus.i_char       = 8'h41;
      @(negedge clk);
      checks++;
      if (bus.o_wr_en !== 1'b1 || bus.o_wr_addr !== 10'd0 || bus.o_wr_data !== 8'h41) begin
         errors++;
         $display("FAIL b2b_A: en=%b addr=%0d data=%h, want 1 0 41",
                  bus.o_wr_en, bus.o_wr_addr, bus.o_wr_data);
      end
      bus.i_char = 8'h42;
      @(negedge clk);
      checks++;
      if (bus.o_wr_en !== 1'b1 || bus.o_wr_addr !== 10'd1 || bus.o_wr_data !== 8'h42) begin
         errors++;
         $display("FAIL b2b_B: en=%b addr=%0d data=%h, want 1 1 42",
                  bus.o_wr_en, bus.o_wr_addr, bus.o_wr_data);
      end
      bus.i_char_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (bus.o_wr_en !== 1'b0 || bus.o_cursor_col !== 5'd2 || bus.o_cursor_row !== 5'd0) begin
         errors++;
         $display("FAIL b2b_idle: en=%b col=%0d row=%0d, want 0 2 0",
                  bus.o_wr_en, bus.o_cursor_col, bus.o_cursor_row);
      end
   endtask

   task automatic test_row_fill();
      bus.i_char_valid = 1'b1;
      bus.i_char       = 8'h0D;
      @(negedge clk);
      checks++;
      if (bus.o_wr_en !== 1'b0 || bus.o_cursor_col !== 5'd0) begin
         errors++;
         $display("FAIL cr: en=%b col=%0d, want 0 0", bus.o_wr_en, bus.o_cursor_col);
      end
      for (int i = 0; i < 32; i++) begin
         bus.i_char = 8'h30 + 8'(i);
         @(negedge clk);
         checks++;
         if (bus.o_wr_en !== 1'b1 || bus.o_wr_addr !== 10'(i) || bus.o_wr_data !== 8'h30 + 8'(i) ||
             bus.o_char_ready !== 1'b1) begin
            errors++;
            $display("FAIL row_char[%0d]: en=%b addr=%0d data=%h rdy=%b, want 1 %0d %h 1",
                     i, bus.o_wr_en, bus.o_wr_addr, bus.o_wr_data, bus.o_char_ready, i, 8'h30 + 8'(i));
         end
      end
      bus.i_char_valid = 1'b0;
      checks++;
      if (bus.o_cursor_row !== 5'd1 || bus.o_cursor_col !== 5'd0 || bus.o_scroll_row !== 5'd0) begin
         errors++;
         $display("FAIL wrap_cursor: row=%0d col=%0d scroll=%0d, want 1 0 0",
                  bus.o_cursor_row, bus.o_cursor_col, bus.o_scroll_row);
      end
      @(negedge clk);
      checks++;
      if (bus.o_wr_en !== 1'b0 || bus.o_char_ready !== 1'b1 || bus.o_busy !== 1'b0) begin
         errors++;
         $display("FAIL wrap_no_clear: en=%b rdy=%b busy=%b, want 0 1 0",
                  bus.o_wr_en, bus.o_char_ready, bus.o_busy);
      end
   endtask

   task automatic test_backspace();
      bus.i_char_valid = 1'b1;
      bus.i_char       = 8'h08;
      @(negedge clk);
      checks++;
      if (bus.o_wr_en !== 1'b0 || bus.o_cursor_col !== 5'd0 || bus.o_cursor_row !== 5'd1) begin
         errors++;
         $display("FAIL bs_col0: en=%b col=%0d row=%0d, want 0 0 1",
                  bus.o_wr_en, bus.o_cursor_col, bus.o_cursor_row);
      end
      bus.i_char = 8'h58;
      @(negedge clk);
      checks++;
      if (bus.o_wr_en !== 1'b1 || bus.o_wr_addr !== 10'd32 || bus.o_wr_data !== 8'h58 ||
          bus.o_cursor_col !== 5'd1) begin
         errors++;
         $display("FAIL bs_X: en=%b addr=%0d data=%h col=%0d, want 1 32 58 1",
                  bus.o_wr_en, bus.o_wr_addr, bus.o_wr_data, bus.o_cursor_col);
      end
      bus.i_char = 8'h08;
      @(negedge clk);
      bus.i_char_valid = 1'b0;
      checks++;
      if (bus.o_wr_en !== 1'b1 || bus.o_wr_addr !== 10'd32 || bus.o_wr_data !== 8'h20 ||
          bus.o_cursor_col !== 5'd0) begin
         errors++;
         $display("FAIL bs_erase: en=%b addr=%0d data=%h col=%0d, want 1 32 20 0",
                  bus.o_wr_en, bus.o_wr_addr, bus.o_wr_data, bus.o_cursor_col);
      end
   endtask

   task automatic test_clear_in_idle();
      int n = 0;
      bus.i_clear      = 1'b1;
      bus.i_char_valid = 1'b1;
      bus.i_char       = 8'h51;
      #1;
      checks++;
      if (bus.o_char_ready !== 1'b0) begin
         errors++;
         $display("FAIL clear_blocks_ready: rdy=%b, want 0", bus.o_char_ready);
      end
      @(negedge clk);
      bus.i_clear      = 1'b0;
      bus.i_char_valid = 1'b0;
      checks++;
      if (bus.o_wr_en !== 1'b0 || bus.o_busy !== 1'b1) begin
         errors++;
         $display("FAIL clear_char_dropped: en=%b busy=%b, want 0 1", bus.o_wr_en, bus.o_busy);
      end
      while (bus.o_busy === 1'b1 && n < 1100) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (bus.o_busy !== 1'b0 || bus.o_cursor_row !== 5'd0 || bus.o_cursor_col !== 5'd0 ||
          bus.o_scroll_row !== 5'd0 || bus.o_char_ready !== 1'b1) begin
         errors++;
         $display("FAIL clear_idle_done: busy=%b row=%0d col=%0d scroll=%0d rdy=%b after %0d cycles, want 0 0 0 0 1",
                  bus.o_busy, bus.o_cursor_row, bus.o_cursor_col, bus.o_scroll_row,
                  bus.o_char_ready, n);
      end
   endtask

   task automatic test_lf_scroll();
      bus.i_char_valid = 1'b1;
      bus.i_char       = 8'h0A;
      for (int k = 1; k < 32; k++) begin
         @(negedge clk);
         checks++;
         if (bus.o_wr_en !== 1'b0 || bus.o_cursor_row !== 5'(k) || bus.o_cursor_col !== 5'd0 ||
             bus.o_char_ready !== 1'b1) begin
            errors++;
            $display("FAIL lf[%0d]: en=%b row=%0d col=%0d rdy=%b, want 0 %0d 0 1",
                     k, bus.o_wr_en, bus.o_cursor_row, bus.o_cursor_col, bus.o_char_ready, k);
         end
      end
      @(negedge clk);
      bus.i_char_valid = 1'b0;
      checks++;
      if (bus.o_cursor_row !== 5'd0 || bus.o_scroll_row !== 5'd1 || bus.o_wr_en !== 1'b1 ||
          bus.o_wr_addr !== 10'd0 || bus.o_wr_data !== 8'h20 || bus.o_char_ready !== 1'b0) begin
         errors++;
         $display("FAIL lf_scroll: row=%0d scroll=%0d en=%b addr=%0d data=%h rdy=%b, want 0 1 1 0 20 0",
                  bus.o_cursor_row, bus.o_scroll_row, bus.o_wr_en, bus.o_wr_addr,
                  bus.o_wr_data, bus.o_char_ready);
      end
      for (int j = 1; j < 32; j++) begin
         @(negedge clk);
         checks++;
         if (bus.o_wr_en !== 1'b1 || bus.o_wr_addr !== 10'(j) || bus.o_wr_data !== 8'h20 ||
             bus.o_char_ready !== 1'b0) begin
            errors++;
            $display("FAIL line_clear[%0d]: en=%b addr=%0d data=%h rdy=%b, want 1 %0d 20 0",
                     j, bus.o_wr_en, bus.o_wr_addr, bus.o_wr_data, bus.o_char_ready, j);
         end
      end
      @(negedge clk);
      checks++;
      if (bus.o_char_ready !== 1'b1 || bus.o_wr_en !== 1'b0 || bus.o_busy !== 1'b0) begin
         errors++;
         $display("FAIL line_clear_done: rdy=%b en=%b busy=%b, want 1 0 0",
                  bus.o_char_ready, bus.o_wr_en, bus.o_busy);
      end
   endtask

   task automatic test_clear_abort();
      // Cursor row 0, scroll 1: one LF fills the screen and clears row 1.
      bus.i_char_valid = 1'b1;
      bus.i_char       = 8'h0A;
      @(negedge clk);
      bus.i_char_valid = 1'b0;
      checks++;
      if (bus.o_cursor_row !== 5'd1 || bus.o_scroll_row !== 5'd2 || bus.o_wr_en !== 1'b1 ||
          bus.o_wr_addr !== 10'd32) begin
         errors++;
         $display("FAIL abort_start: row=%0d scroll=%0d en=%b addr=%0d, want 1 2 1 32",
                  bus.o_cursor_row, bus.o_scroll_row, bus.o_wr_en, bus.o_wr_addr);
      end
      for (int j = 1; j < 10; j++) begin
         @(negedge clk);
         checks++;
         if (bus.o_wr_en !== 1'b1 || bus.o_wr_addr !== 10'(32 + j)) begin
            errors++;
            $display("FAIL abort_line[%0d]: en=%b addr=%0d, want 1 %0d",
                     j, bus.o_wr_en, bus.o_wr_addr, 32 + j);
         end
      end
      bus.i_clear      = 1'b1;
      bus.i_char_valid = 1'b1;
      bus.i_char       = 8'h5A;
      #1;
      checks++;
      if (bus.o_char_ready !== 1'b0) begin
         errors++;
         $display("FAIL abort_ready: rdy=%b, want 0", bus.o_char_ready);
      end
      @(negedge clk);
      bus.i_clear = 1'b0;
      checks++;
      if (bus.o_wr_en !== 1'b0 || bus.o_busy !== 1'b1 || bus.o_char_ready !== 1'b0) begin
         errors++;
         $display("FAIL abort_gap: en=%b busy=%b rdy=%b, want 0 1 0",
                  bus.o_wr_en, bus.o_busy, bus.o_char_ready);
      end
      for (int i = 0; i < 1024; i++) begin
         @(negedge clk);
         checks++;
         if (bus.o_wr_en !== 1'b1 || bus.o_wr_addr !== 10'(i) || bus.o_wr_data !== 8'h20 ||
             bus.o_char_ready !== 1'b0) begin
            errors++;
            $display("FAIL refill[%0d]: en=%b addr=%0d data=%h rdy=%b, want 1 %0d 20 0",
                     i, bus.o_wr_en, bus.o_wr_addr, bus.o_wr_data, bus.o_char_ready, i);
         end
      end
      @(negedge clk);
      bus.i_char_valid = 1'b0;
      checks++;
      if (bus.o_wr_en !== 1'b0 || bus.o_char_ready !== 1'b1 || bus.o_cursor_row !== 5'd0 ||
          bus.o_cursor_col !== 5'd0 || bus.o_scroll_row !== 5'd0) begin
         errors++;
         $display("FAIL refill_done: en=%b rdy=%b row=%0d col=%0d scroll=%0d, want 0 1 0 0 0",
                  bus.o_wr_en, bus.o_char_ready, bus.o_cursor_row, bus.o_cursor_col,
                  bus.o_scroll_row);
      end
   endtask

   task automatic test_async_reset();
      int n = 0;
      bus.i_clear = 1'b1;
      @(negedge clk);
      bus.i_clear = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if (bus.o_wr_en !== 1'b1 || bus.o_wr_addr !== 10'd2) begin
         errors++;
         $display("FAIL pre_reset_fill: en=%b addr=%0d, want 1 2", bus.o_wr_en, bus.o_wr_addr);
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (bus.o_wr_en !== 1'b0 || bus.o_wr_addr !== 10'd0 || bus.o_wr_data !== 8'h00 ||
          bus.o_busy !== 1'b1) begin
         errors++;
         $display("FAIL async_reset: en=%b addr=%0d data=%h busy=%b, want 0 0 00 1",
                  bus.o_wr_en, bus.o_wr_addr, bus.o_wr_data, bus.o_busy);
      end
      @(negedge clk);
      rst_n = 1'b1;
      while (bus.o_busy === 1'b1 && n < 1100) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (bus.o_busy !== 1'b0 || bus.o_char_ready !== 1'b1 || bus.o_cursor_row !== 5'd0 ||
          bus.o_scroll_row !== 5'd0) begin
         errors++;
         $display("FAIL post_reset_fill: busy=%b rdy=%b row=%0d scroll=%0d after %0d cycles, want 0 1 0 0",
                  bus.o_busy, bus.o_char_ready, bus.o_cursor_row, bus.o_scroll_row, n);
      end
   endtask

   initial begin
      bus.i_char_valid = 1'b0;
      bus.i_char       = 8'h00;
      bus.i_clear      = 1'b0;
      test_reset();
      test_back_to_back();
      test_row_fill();
      test_backspace();
      test_clear_in_idle();
      test_lf_scroll();
      test_clear_abort();
      test_async_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
